// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the two-port data_mem front end.
// Imported by the interface, the arbiter sub-module and the top level.
package data_mem_arbiter_pkg;

   localparam int DATA_W = 32;
   localparam int MASK_W = 4;
   localparam int WDOG_W = 8;

   localparam int                DEF_TIMEOUT_CYCLES = 16;
   localparam logic [DATA_W-1:0] DEF_ERR_RDATA      = 32'h0000_0000;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_ISSUE      = 3'd1,
      ST_WAIT_START = 3'd2,
      ST_WAIT_DONE  = 3'd3,
      ST_RESP       = 3'd4
   } state_e;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DMA = 1'b1
   } req_id_e;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester-side bus of the data_mem arbiter: one instance per requester.
// The requester drives the master modport, the arbiter sits on the slave modport.
interface data_mem_arbiter_if;
   import data_mem_arbiter_pkg::*;

   logic              req;
   logic              we;
   logic [DATA_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [MASK_W-1:0] sign_mask;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, addr, wdata, sign_mask,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, wdata, sign_mask,
      output ack, rdata
   );

endinterface

// File: rtl/data_mem_arbiter_rr_arbiter_2.sv
// Two-way grant: fixed CPU priority or round-robin on ties.
// The tie pointer only moves when the caller confirms a grant.
module rr_arbiter_2 import data_mem_arbiter_pkg::*; (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   input  logic       cpu_priority_i,
   input  logic       update_i,
   output logic       valid_o,
   output req_id_e    gnt_o
);

   req_id_e ptr_q;
   req_id_e ptr_d;

   always_comb begin
      valid_o = |req_i;
      if (req_i[REQ_CPU] && req_i[REQ_DMA]) begin
         gnt_o = cpu_priority_i ? REQ_CPU : ptr_q;
      end else if (req_i[REQ_DMA]) begin
         gnt_o = REQ_DMA;
      end else begin
         gnt_o = REQ_CPU;
      end
      // Favour whoever did not just win.
      ptr_d = (gnt_o == REQ_CPU) ? REQ_DMA : REQ_CPU;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= REQ_CPU;
      end else if (update_i) begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares data_mem between the CPU MEM stage and a DMA/debug port, one
// transaction at a time through data_mem's request/stall handshake, with a watchdog.
module data_mem_arbiter import data_mem_arbiter_pkg::*; #(
   parameter bit                CPU_PRIORITY   = 1'b0,
   parameter int                TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter logic [DATA_W-1:0] ERR_RDATA      = DEF_ERR_RDATA
) (
   input  logic              clk,
   input  logic              reset,
   data_mem_arbiter_if.slave cpu,
   data_mem_arbiter_if.slave dma,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_memread,
   output logic              mem_memwrite,
   output logic [MASK_W-1:0] mem_sign_mask,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic              mem_clk_stall,
   output logic              busy,
   output logic              timeout_err
);

   localparam logic [WDOG_W-1:0] TIMEOUT_L = WDOG_W'(TIMEOUT_CYCLES);

   state_e            state_q;
   req_id_e           gnt_q;
   logic              we_q;
   logic [DATA_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [MASK_W-1:0] mask_q;
   logic              memread_q;
   logic              memwrite_q;
   logic              cpu_ack_q;
   logic              dma_ack_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dma_rdata_q;
   logic [WDOG_W-1:0] wdog_q;
   logic [WDOG_W-1:0] wdog_d;
   logic              timeout_q;

   logic              arb_valid;
   req_id_e           arb_gnt;
   logic              grant_en;
   logic              done_ok;
   logic              abort;
   logic              finish;
   logic [DATA_W-1:0] fin_rdata;
   logic              sel_we;
   logic [DATA_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [MASK_W-1:0] sel_mask;

   rr_arbiter_2 u_arb (
      .clk            (clk),
      .reset          (reset),
      .req_i          ({dma.req, cpu.req}),
      .cpu_priority_i (CPU_PRIORITY),
      .update_i       (grant_en),
      .valid_o        (arb_valid),
      .gnt_o          (arb_gnt)
   );

   always_comb begin
      sel_we    = (arb_gnt == REQ_DMA) ? dma.we        : cpu.we;
      sel_addr  = (arb_gnt == REQ_DMA) ? dma.addr      : cpu.addr;
      sel_wdata = (arb_gnt == REQ_DMA) ? dma.wdata     : cpu.wdata;
      sel_mask  = (arb_gnt == REQ_DMA) ? dma.sign_mask : cpu.sign_mask;

      // data_mem has no reset, so a stall still high after our reset blocks new grants.
      grant_en  = (state_q == ST_IDLE) && arb_valid && !mem_clk_stall;
      wdog_d    = wdog_q + 1'b1;
      done_ok   = (state_q == ST_WAIT_DONE) && !mem_clk_stall;
      abort     = (wdog_d == TIMEOUT_L) &&
                  (((state_q == ST_WAIT_START) && !mem_clk_stall) ||
                   ((state_q == ST_WAIT_DONE)  &&  mem_clk_stall));
      finish    = done_ok || abort;
      fin_rdata = abort ? ERR_RDATA : mem_read_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         gnt_q       <= REQ_CPU;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mask_q      <= '0;
         memread_q   <= 1'b0;
         memwrite_q  <= 1'b0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
         wdog_q      <= '0;
         timeout_q   <= 1'b0;
      end else begin
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         cpu_ack_q  <= 1'b0;
         dma_ack_q  <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (grant_en) begin
                  gnt_q      <= arb_gnt;
                  we_q       <= sel_we;
                  addr_q     <= sel_addr;
                  wdata_q    <= sel_wdata;
                  mask_q     <= sel_mask;
                  memread_q  <= ~sel_we;
                  memwrite_q <= sel_we;
                  state_q    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               wdog_q  <= '0;
               state_q <= ST_WAIT_START;
            end
            ST_WAIT_START: begin
               if (mem_clk_stall) begin
                  wdog_q  <= '0;
                  state_q <= ST_WAIT_DONE;
               end else begin
                  wdog_q <= wdog_d;
               end
            end
            ST_WAIT_DONE: begin
               wdog_q <= wdog_d;
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase

         // Normal completion and watchdog abort both end in a single acked RESP cycle.
         if (finish) begin
            state_q <= ST_RESP;
            if (abort) begin
               timeout_q <= 1'b1;
            end
            if (gnt_q == REQ_CPU) begin
               cpu_ack_q <= 1'b1;
               if (!we_q) begin
                  cpu_rdata_q <= fin_rdata;
               end
            end else begin
               dma_ack_q <= 1'b1;
               if (!we_q) begin
                  dma_rdata_q <= fin_rdata;
               end
            end
         end
      end
   end

   assign mem_addr       = addr_q;
   assign mem_write_data = wdata_q;
   assign mem_sign_mask  = mask_q;
   assign mem_memread    = memread_q;
   assign mem_memwrite   = memwrite_q;
   assign cpu.ack        = cpu_ack_q;
   assign dma.ack        = dma_ack_q;
   assign cpu.rdata      = cpu_rdata_q;
   assign dma.rdata      = dma_rdata_q;
   assign busy           = (state_q != ST_IDLE);
   assign timeout_err    = timeout_q;

endmodule
